// File: rtl/bus_pkg.sv
// Shared types for the two-master memory bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;
    typedef enum logic {OWNER_M0, OWNER_M1} owner_t;

    localparam int RD_LATENCY_MAX = 4;

    // One slot of the read-return pipeline.
    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

    function automatic arb_state_t own_state(input owner_t o);
        return (o == OWNER_M1) ? ARB_OWN1 : ARB_OWN0;
    endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational two-way round-robin pick: the pointer breaks ties only.
module bus_rr_pick
    import bus_pkg::*;
(
    input  logic   req0_i,
    input  logic   req1_i,
    input  owner_t ptr_i,
    output logic   gnt0_o,
    output logic   gnt1_o
);

    always_comb begin
        gnt0_o = req0_i && (!req1_i || (ptr_i == OWNER_M0));
        gnt1_o = req1_i && (!req0_i || (ptr_i == OWNER_M1));
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory port between m0 (core) and m1 (GPU/DMA).
// Define BUS_ARB_BURST_EN to let the current owner hold the bus for up to MAX_BURST issues.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int TAG_DEPTH = (RD_LATENCY < 1) ? 1 :
                               (RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : RD_LATENCY;

    owner_t     ptr_q, ptr_d;
    arb_state_t state_q, state_d;
    rd_tag_t [TAG_DEPTH-1:0] tag_q, tag_d;
    rd_tag_t    tag_out;

    logic   pick0, pick1;
    logic   win0, win1;
    logic   issue;
    owner_t win_owner;

    bus_rr_pick u_pick (
        .req0_i (m0_req),
        .req1_i (m1_req),
        .ptr_i  (ptr_q),
        .gnt0_o (pick0),
        .gnt1_o (pick1)
    );

`ifdef BUS_ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    // Count of consecutive issues by the current owner, including the latest one.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic keep0, keep1;

    always_comb begin
        keep0 = (state_q == ARB_OWN0) && m0_req && ((cnt_q < CNT_MAX) || !m1_req);
        keep1 = (state_q == ARB_OWN1) && m1_req && ((cnt_q < CNT_MAX) || !m0_req);
        win0  = keep0 || (!keep1 && pick0);
        win1  = keep1 || (!keep0 && pick1);
    end

    always_comb begin
        cnt_d = '0;
        if (issue) begin
            if (state_q == own_state(win_owner)) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
                cnt_d = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without bursting the owner FSM is tracked but never steers the pick.
    logic burst_unused;
    assign burst_unused = ^{state_q, MAX_BURST};

    always_comb begin
        win0 = pick0;
        win1 = pick1;
    end
`endif

    assign m0_gnt    = reset & win0;
    assign m1_gnt    = reset & win1;
    assign issue     = m0_gnt | m1_gnt;
    assign win_owner = m1_gnt ? OWNER_M1 : OWNER_M0;

    always_comb begin
        // NOTE: every signal gets a default before the branches, so no path can infer a latch.
        mem_en    = issue;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    always_comb begin
        state_d = issue ? own_state(win_owner) : ARB_IDLE;
        ptr_d   = ptr_q;
        if (issue) begin
            ptr_d = (win_owner == OWNER_M0) ? OWNER_M1 : OWNER_M0;
        end
        tag_d[0].valid = issue & ~mem_we;
        tag_d[0].owner = win_owner;
        for (int i = 1; i < TAG_DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            ptr_q   <= OWNER_M0;
            state_q <= ARB_IDLE;
            tag_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            state_q <= state_d;
            tag_q   <= tag_d;
        end
    end

    assign tag_out   = tag_q[TAG_DEPTH-1];
    assign m0_rvalid = tag_out.valid && (tag_out.owner == OWNER_M0);
    assign m1_rvalid = tag_out.valid && (tag_out.owner == OWNER_M1);
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench: four arbiters (RD_LATENCY 1..4) share stimulus and a bench memory model.
module tb_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        m0_gnt_w    [1:4];
    logic        m0_rvalid_w [1:4];
    logic [31:0] m0_rdata_w  [1:4];
    logic        m1_gnt_w    [1:4];
    logic        m1_rvalid_w [1:4];
    logic [31:0] m1_rdata_w  [1:4];
    logic        mem_en_w    [1:4];
    logic        mem_we_w    [1:4];
    logic [31:0] mem_addr_w  [1:4];
    logic [31:0] mem_wdata_w [1:4];
    logic [31:0] mem_rdata_w [1:4];

    logic [31:0] ram     [0:255];
    logic [31:0] rd_pipe [0:3];
    bit          ram_ready;

    int total;
    int bad;
    int cyc;
    bit          exp_v [0:511];
    bit          exp_o [0:511];
    logic [31:0] exp_d [0:511];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar l = 1; l <= 4; l++) begin : g_dut
        bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(l), .MAX_BURST(4)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .m0_req    (m0_req),
            .m0_we     (m0_we),
            .m0_addr   (m0_addr),
            .m0_wdata  (m0_wdata),
            .m0_gnt    (m0_gnt_w[l]),
            .m0_rvalid (m0_rvalid_w[l]),
            .m0_rdata  (m0_rdata_w[l]),
            .m1_req    (m1_req),
            .m1_we     (m1_we),
            .m1_addr   (m1_addr),
            .m1_wdata  (m1_wdata),
            .m1_gnt    (m1_gnt_w[l]),
            .m1_rvalid (m1_rvalid_w[l]),
            .m1_rdata  (m1_rdata_w[l]),
            .mem_en    (mem_en_w[l]),
            .mem_we    (mem_we_w[l]),
            .mem_addr  (mem_addr_w[l]),
            .mem_wdata (mem_wdata_w[l]),
            .mem_rdata (mem_rdata_w[l])
        );
        assign mem_rdata_w[l] = rd_pipe[l-1];
    end

    // Memory: word at byte address A initially reads 0xC0DE_0000 | A; data appears N cycles after issue.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int k = 0; k < 256; k++) ram[k] <= 32'hC0DE_0000 | (32'(k) << 2);
            ram_ready <= 1'b1;
        end else if (mem_en_w[1] && mem_we_w[1]) begin
            ram[mem_addr_w[1][9:2]] <= mem_wdata_w[1];
        end
        rd_pipe[0] <= ram[mem_addr_w[1][9:2]];
        for (int k = 1; k < 4; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit r0, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                         input bit r1, input bit we1, input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic clear_log();
        for (int i = 0; i < 512; i++) exp_v[i] = 1'b0;
    endtask

    // One cycle: check the issue-side outputs, then the read returns due from earlier issues.
    task automatic step(input bit g0, input bit g1, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdat);
        @(negedge clk);
        for (int l = 1; l <= 4; l++) begin
            check($sformatf("m0_gnt@lat%0d c%0d", l, cyc), 32'(m0_gnt_w[l]), 32'(g0));
            check($sformatf("m1_gnt@lat%0d c%0d", l, cyc), 32'(m1_gnt_w[l]), 32'(g1));
        end
        check($sformatf("mem_en c%0d", cyc), 32'(mem_en_w[1]), 32'(g0 | g1));
        check($sformatf("mem_we c%0d", cyc), 32'(mem_we_w[1]), 32'((g0 | g1) & we));
        if (g0 | g1) begin
            check($sformatf("mem_addr c%0d", cyc), mem_addr_w[1], addr);
            check($sformatf("mem_wdata c%0d", cyc), mem_wdata_w[1], wdata);
        end
        if (!reset) begin
            check($sformatf("rst mem_addr c%0d", cyc), mem_addr_w[1], 32'h0);
            check($sformatf("rst mem_wdata c%0d", cyc), mem_wdata_w[1], 32'h0);
        end
        for (int n = 1; n <= 4; n++) begin
            bit          e0, e1;
            logic [31:0] ed;
            int          s;
            s  = cyc - n;
            e0 = 1'b0;
            e1 = 1'b0;
            ed = 32'h0;
            if (s >= 0) begin
                e0 = exp_v[s] && !exp_o[s];
                e1 = exp_v[s] && exp_o[s];
                ed = exp_d[s];
            end
            check($sformatf("m0_rvalid@lat%0d c%0d", n, cyc), 32'(m0_rvalid_w[n]), 32'(e0));
            check($sformatf("m1_rvalid@lat%0d c%0d", n, cyc), 32'(m1_rvalid_w[n]), 32'(e1));
            check($sformatf("m0_rdata@lat%0d c%0d", n, cyc), m0_rdata_w[n], e0 ? ed : 32'h0);
            check($sformatf("m1_rdata@lat%0d c%0d", n, cyc), m1_rdata_w[n], e1 ? ed : 32'h0);
        end
        exp_v[cyc] = (g0 | g1) & ~we;
        exp_o[cyc] = g1;
        exp_d[cyc] = rdat;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [5:0] who1;
        total = 0;
        bad   = 0;
        cyc   = 0;
        reset = 1'b0;
        drive(1, 0, 32'h0, 32'h0, 1, 0, 32'h4, 32'h0);
        @(posedge clk);
        #1;

        // Reset with both requesting: nothing granted; on release m0 wins first.
        step(0, 0, 0, 32'h0, 32'h0, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0, 32'h0);
        reset = 1'b1;
        step(1, 0, 0, 32'h0, 32'h0, 32'hC0DE_0000);
        idle(5);

        // Solo m1: four back-to-back reads, no bubbles.
        drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h100, 32'h0);
        step(0, 1, 0, 32'h100, 32'h0, 32'hC0DE_0100);
        drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h104, 32'h0);
        step(0, 1, 0, 32'h104, 32'h0, 32'hC0DE_0104);
        drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h108, 32'h0);
        step(0, 1, 0, 32'h108, 32'h0, 32'hC0DE_0108);
        drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h10C, 32'h0);
        step(0, 1, 0, 32'h10C, 32'h0, 32'hC0DE_010C);
        idle(5);

        // Contention for six cycles; bit i set means m1 wins cycle i.
`ifdef BUS_ARB_BURST_EN
        who1 = 6'b110000;
`else
        who1 = 6'b101010;
`endif
        drive(1, 0, 32'h200, 32'h0, 1, 0, 32'h300, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step(!who1[i], who1[i], 0, who1[i] ? 32'h300 : 32'h200, 32'h0,
                 who1[i] ? 32'hC0DE_0300 : 32'hC0DE_0200);
        end
        idle(5);

        // m0 writes, m1 reads the same word back next cycle.
        drive(1, 1, 32'h40, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0);
        step(1, 0, 1, 32'h40, 32'hDEAD_BEEF, 32'h0);
        drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
        step(0, 1, 0, 32'h40, 32'h0, 32'hDEAD_BEEF);
        idle(5);

        // A read in flight is dropped by a one-cycle reset pulse.
        drive(1, 0, 32'h80, 32'h0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h80, 32'h0, 32'hC0DE_0080);
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        reset = 1'b0;
        clear_log();
        step(0, 0, 0, 32'h0, 32'h0, 32'h0);
        reset = 1'b1;
        idle(6);

        // Alternating owners, one read per cycle, across all four latencies.
        drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h10, 32'h0, 32'hC0DE_0010);
        drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h14, 32'h0);
        step(0, 1, 0, 32'h14, 32'h0, 32'hC0DE_0014);
        drive(1, 0, 32'h18, 32'h0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h18, 32'h0, 32'hC0DE_0018);
        drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h1C, 32'h0);
        step(0, 1, 0, 32'h1C, 32'h0, 32'hC0DE_001C);
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
